// File: rtl/apb_ctrl_pkg.sv
// Shared types and defaults for the round-robin APB master.
package apb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RCAP   = 2'd3
    } apb_state_e;

    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_ADDR_WIDTH    = 8;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_RD_SAMPLE_DLY = 1;
    localparam int DEF_TIMEOUT       = 16;

    // Read data returned on a watchdog abort; sliced down to DATA_WIDTH (<= 64).
    localparam logic [63:0] ERR_RDATA = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after last_grant+1.
module rr_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [IDX_W-1:0]   ptr
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             found;
    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand     = (int'(ptr_q) + 1 + k) % NUM_REQ;
            cand_idx = cand[IDX_W-1:0];
            if (!found && req[cand_idx]) begin
                found     = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign grant[gi] = found && (grant_idx == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = grant_idx;
        end
    end

    // Pointer starts at the last requester so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/apb_rr_master.sv
// Multi-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// optional delayed read capture and a PREADY watchdog.
module apb_rr_master
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int RD_SAMPLE_DLY = DEF_RD_SAMPLE_DLY,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input  logic                            PCLK,
    input  logic                            PRESET,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_slverr,
    output logic [ADDR_WIDTH-1:0]           PADDR,
    output logic                            PSEL,
    output logic                            PENABLE,
    output logic                            PWRITE,
    output logic [DATA_WIDTH-1:0]           PWDATA,
    output logic [DATA_WIDTH/8-1:0]         PSTRB,
    input  logic [DATA_WIDTH-1:0]           PRDATA,
    input  logic                            PREADY,
    input  logic                            PSLVERR
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    apb_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       strb_q, strb_d;
    logic [WD_W-1:0]         wdog_q, wdog_d;
    logic                    slverr_cap_q, slverr_cap_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_slverr_q, rsp_slverr_d;

    logic                    arb_window;
    logic                    arb_any;
    logic [NUM_REQ-1:0]      arb_grant;
    logic [IDX_W-1:0]        arb_idx;
    logic [IDX_W-1:0]        owner;

    logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];
    logic [STRB_W-1:0]       strb_arr  [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign strb_arr[gi]  = req_strb[gi*STRB_W +: STRB_W];
        end
    endgenerate

    // The arbiter's last-grant pointer doubles as the owner of the transfer in flight.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (PCLK),
        .rst       (PRESET),
        .req       (req_valid),
        .advance   (arb_window && arb_any),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .ptr       (owner)
    );

    assign arb_any = |arb_grant;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        strb_d       = strb_q;
        wdog_d       = wdog_q;
        slverr_cap_d = slverr_cap_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_slverr_d = rsp_slverr_q;
        arb_window   = 1'b0;

        case (state_q)
            IDLE: begin
                arb_window = 1'b1;
            end
            SETUP: begin
                state_d = ACCESS;
                wdog_d  = '0;
            end
            ACCESS: begin
                if (PREADY) begin
                    if (write_q || (RD_SAMPLE_DLY == 0)) begin
                        rsp_valid_d[owner] = 1'b1;
                        rsp_rdata_d        = write_q ? '0 : PRDATA;
                        rsp_slverr_d       = PSLVERR;
                        state_d            = IDLE;
                        arb_window         = 1'b1;
                    end else begin
                        slverr_cap_d = PSLVERR;
                        state_d      = RCAP;
                    end
                end else if ((TIMEOUT != 0) && (wdog_q == WD_LAST)) begin
                    rsp_valid_d[owner] = 1'b1;
                    rsp_rdata_d        = ERR_RDATA[DATA_WIDTH-1:0];
                    rsp_slverr_d       = 1'b1;
                    state_d            = IDLE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            RCAP: begin
                rsp_valid_d[owner] = 1'b1;
                rsp_rdata_d        = PRDATA;
                rsp_slverr_d       = slverr_cap_q;
                state_d            = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A grant in the window overrides the IDLE fallback, giving back-to-back SETUP.
        if (arb_window && arb_any) begin
            state_d = SETUP;
            addr_d  = addr_arr[arb_idx];
            write_d = req_write[arb_idx];
            wdata_d = wdata_arr[arb_idx];
            strb_d  = strb_arr[arb_idx];
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            strb_q       <= '0;
            wdog_q       <= '0;
            slverr_cap_q <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            strb_q       <= strb_d;
            wdog_q       <= wdog_d;
            slverr_cap_q <= slverr_cap_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_slverr_q <= rsp_slverr_d;
        end
    end

    assign req_ready  = (arb_window && !PRESET) ? arb_grant : '0;

    assign PSEL       = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE    = (state_q == ACCESS);
    assign PADDR      = addr_q;
    assign PWRITE     = write_q;
    assign PWDATA     = write_q ? wdata_q : '0;
    assign PSTRB      = write_q ? strb_q : '0;

    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_slverr = rsp_slverr_q;

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Multi-requester APB master.
- Arbitrates round-robin among NUM_REQ local command ports and sequences the chosen command through APB SETUP/ACCESS phases to one shared apb_slave.
- Returns read data and error status to the granted requester.
- Bounds slave stalls with a PREADY timeout watchdog.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- ADDR_WIDTH, 8, APB address width.
- DATA_WIDTH, 32, APB data width (multiple of 8).
- RD_SAMPLE_DLY, 1, 0 = sample PRDATA in the ACCESS cycle with PREADY high; 1 = sample PRDATA one cycle later (for slaves with registered read data).
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables the watchdog.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  command request per requester.
- req_ready  out  NUM_REQ  one-hot accept; command consumed on PCLK edge where valid&ready.
- req_write  in  NUM_REQ  1 = write.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_strb  in  NUM_REQ*DATA_WIDTH/8  packed byte strobes.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid; 0 for writes.
- rsp_slverr  out  1  error status, valid with rsp_valid.
- PADDR  out  ADDR_WIDTH  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSTRB  out  DATA_WIDTH/8  APB strobes.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Reset (PRESET=1, asynchronous):
  - state=IDLE; all APB outputs, rsp_valid, rsp_rdata and rsp_slverr = 0.
  - req_ready forced 0 while PRESET is high.
  - RR pointer set so requester 0 has highest priority.
- FSM states: IDLE, SETUP, ACCESS, RCAP.
- Arbitration window: IDLE, or ACCESS with PREADY=1 and no RCAP needed.
  - Grant = first req_valid at or after (last_grant+1) mod NUM_REQ.
  - req_ready = grant one-hot (combinational); 0 outside the window.
  - On the edge: latch addr/write/wdata/strb/owner, update last_grant, next state = SETUP.
- SETUP (1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB from latched command. PSTRB=0 and PWDATA=0 for reads. Next state = ACCESS.
- ACCESS: PSEL=1, PENABLE=1; APB outputs held stable until PREADY=1.
  - PREADY=1, write or RD_SAMPLE_DLY=0:
    - next cycle rsp_valid[owner]=1, rsp_rdata=PRDATA (reads) or 0 (writes), rsp_slverr=PSLVERR.
    - Same edge re-arbitrates: a pending request goes straight to SETUP (back-to-back, PSEL stays 1, PENABLE drops); otherwise IDLE.
  - PREADY=1, read, RD_SAMPLE_DLY=1: capture PSLVERR; go to RCAP.
- RCAP (1 cycle): PSEL=0, PENABLE=0; capture PRDATA; next cycle rsp_valid pulse; next state = IDLE.
- Watchdog:
  - Counter clears on entering ACCESS and counts ACCESS cycles with PREADY=0.
  - At count == TIMEOUT: drop PSEL/PENABLE; respond rsp_slverr=1, rsp_rdata=all 1s; go to IDLE.
- rsp_valid is a single-cycle pulse per accepted command, exactly one per accept, in accept order.
- No new grant while a transfer is outstanding, except the ACCESS completion edge noted above.
- A requester dropping req_valid before grant is legal; after grant the command is owned internally.
- PRESET mid-transfer: bus returns to idle immediately, no rsp_valid for the aborted command.

Decomposition:
- Package apb_ctrl_pkg holds:
  - typedef enum apb_state_e {IDLE,SETUP,ACCESS,RCAP};
  - default width localparams;
  - localparam ERR_RDATA pattern (all 1s).
- Sub-module rr_arbiter (NUM_REQ): req vector, advance strobe, grant one-hot, grant index, rotating pointer.

Test Plan:
- Write req0 addr 0x10 data 0xA5A5_5A5A strb 0xF, then read 0x10 -> PSEL 2 cycles per transfer; read rsp_rdata=0xA5A5_5A5A, rsp_slverr=0.
- All 4 req_valid held with addrs 0x01..0x04 -> grants 0,1,2,3,0; back-to-back transfers with no IDLE gap for writes.
- Read to addr 0xFF with slave PSLVERR=1 -> rsp_slverr=1 pulse to owner; next grant unaffected.
- PREADY held low 3 cycles, TIMEOUT=16 -> ACCESS lasts 4 cycles, response normal.
- PREADY stuck low, TIMEOUT=16 -> abort after 16 cycles, rsp_rdata=0xFFFF_FFFF, rsp_slverr=1, PSEL=0.
- PRESET pulsed during ACCESS -> PSEL/PENABLE=0 asynchronously, no rsp_valid; next request from req0 granted first.
